// File: rtl/cpu_run_controller_if.sv
// Host-side bus of the run controller: program-load word stream and RAM read-back port.
interface cpu_run_controller_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
);
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output ld_valid, ld_data, ld_last, rd_req, rd_addr,
    input  ld_ready, rd_valid, rd_data
  );

  modport slave (
    input  ld_valid, ld_data, ld_last, rd_req, rd_addr,
    output ld_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/cpu_run_controller.sv
// Owns the single RAM port: loads a program, runs the CPU until PC self-loop,
// cycle limit or abort, and serves host read-back while the CPU is stopped.
module cpu_run_controller #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 16,
  parameter int LOAD_BASE   = 0,
  parameter int HALT_WINDOW = 8,
  parameter int MAX_CYCLES  = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start_i,
  input  logic                run_start_i,
  input  logic                abort_i,
  cpu_run_controller_if.slave host,
  output logic                cpu_rst_o,
  input  logic                cpu_wrEn_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W-1:0]   cpu_wdata_i,
  input  logic [ADDR_W-1:0]   cpu_pc_i,
  output logic [DATA_W-1:0]   cpu_rdata_o,
  output logic                ram_wrEn_o,
  output logic [ADDR_W-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_wdata_o,
  input  logic [DATA_W-1:0]   ram_rdata_i,
  output logic                busy_o,
  output logic                halted_o,
  output logic                timeout_o,
  output logic                load_err_o,
  output logic [31:0]         cycle_count_o,
  output logic [ADDR_W-1:0]   final_pc_o
);

  localparam int SW = $clog2(HALT_WINDOW + 1);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(LOAD_BASE);
  localparam logic [31:0]       CYC_LIM    = 32'(MAX_CYCLES - 1);
  localparam logic [SW-1:0]     STABLE_LIM = SW'(HALT_WINDOW - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, HALT = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] load_addr_q, load_addr_d;
  logic [SW-1:0]     stable_q, stable_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [ADDR_W-1:0] final_pc_q, final_pc_d;
  logic              timeout_q, timeout_d;
  logic              load_err_q, load_err_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] pc_prev_q, pc_prev_d;
  logic              pc_same;

  assign pc_same = (cpu_pc_i == pc_prev_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      load_addr_q <= BASE;
      stable_q    <= '0;
      cycle_q     <= '0;
      final_pc_q  <= '0;
      timeout_q   <= 1'b0;
      load_err_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      pc_prev_q   <= '0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      stable_q    <= stable_d;
      cycle_q     <= cycle_d;
      final_pc_q  <= final_pc_d;
      timeout_q   <= timeout_d;
      load_err_q  <= load_err_d;
      rd_valid_q  <= rd_valid_d;
      pc_prev_q   <= pc_prev_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    stable_d    = stable_q;
    cycle_d     = cycle_q;
    final_pc_d  = final_pc_q;
    timeout_d   = timeout_q;
    load_err_d  = load_err_q;
    rd_valid_d  = 1'b0;
    pc_prev_d   = pc_prev_q;
    ram_wrEn_o  = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;

    case (state_q)
      IDLE, HALT: begin
        if (load_start_i) begin
          state_d     = LOAD;
          load_addr_d = BASE;
          load_err_d  = 1'b0;
        end else if (run_start_i) begin
          state_d   = RUN;
          cycle_d   = '0;
          stable_d  = '0;
          timeout_d = 1'b0;
          pc_prev_d = cpu_pc_i;
        end
        if (host.rd_req) begin
          ram_addr_o = host.rd_addr;
          rd_valid_d = 1'b1;
        end
      end
      LOAD: begin
        if (host.ld_valid) begin
          ram_wrEn_o  = 1'b1;
          ram_addr_o  = load_addr_q;
          ram_wdata_o = host.ld_data;
          if (host.ld_last) begin
            load_addr_d = load_addr_q + 1'b1;
            state_d     = IDLE;
          end else if (load_addr_q == '1) begin
            // top of the address space: keep the word, flag it, never wrap
            load_err_d = 1'b1;
            state_d    = IDLE;
          end else begin
            load_addr_d = load_addr_q + 1'b1;
          end
        end
      end
      RUN: begin
        ram_wrEn_o  = cpu_wrEn_i;
        ram_addr_o  = cpu_addr_i;
        ram_wdata_o = cpu_wdata_i;
        cycle_d     = (cycle_q == '1) ? cycle_q : cycle_q + 1'b1;
        pc_prev_d   = cpu_pc_i;
        stable_d    = pc_same ? stable_q + 1'b1 : '0;
        if (abort_i) begin
          state_d    = HALT;
          final_pc_d = cpu_pc_i;
        end else if (cycle_q == CYC_LIM) begin
          state_d    = HALT;
          final_pc_d = cpu_pc_i;
          timeout_d  = 1'b1;
        end else if (pc_same && stable_q == STABLE_LIM) begin
          state_d    = HALT;
          final_pc_d = cpu_pc_i;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_rst_o     = (state_q != RUN);
  assign cpu_rdata_o   = ram_rdata_i;
  assign busy_o        = (state_q == LOAD) || (state_q == RUN);
  assign halted_o      = (state_q == HALT);
  assign timeout_o     = timeout_q;
  assign load_err_o    = load_err_q;
  assign cycle_count_o = cycle_q;
  assign final_pc_o    = final_pc_q;
  assign host.ld_ready = (state_q == LOAD);
  assign host.rd_valid = rd_valid_q;
  assign host.rd_data  = rd_valid_q ? ram_rdata_i : '0;

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequences one projectCPU2022 instance and its single-port RAM.
- Owns the RAM port: loads a program image from a host word stream, releases the CPU from reset, and detects halt (PC self-loop), cycle-limit timeout or abort.
- Lets the host read RAM back while the CPU is stopped.
- Sits between CPU, RAM and host/testbench; the CPU never drives the RAM directly.

Parameters:
ADDR_W, 13, RAM address width (matches CPU addr_toRAM/PC)
DATA_W, 16, RAM/CPU data width
LOAD_BASE, 0, first RAM address written by a load
HALT_WINDOW, 8, consecutive cycles of unchanged cpu_pc that declare halt (must exceed 4, the longest instruction)
MAX_CYCLES, 1000000, RUN cycle limit before forced timeout halt

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
load_start  in  1  pulse: begin program load
run_start  in  1  pulse: start/restart CPU execution
abort  in  1  pulse: force halt during RUN
ld_valid  in  1  load word valid
ld_ready  out  1  load word accepted when valid&ready
ld_data  in  DATA_W  program word
ld_last  in  1  marks final load word
rd_req  in  1  host RAM read request
rd_addr  in  ADDR_W  host read address
rd_valid  out  1  read data valid
rd_data  out  DATA_W  read data
cpu_rst  out  1  reset to CPU
cpu_wrEn  in  1  CPU write enable
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_pc  in  ADDR_W  CPU PC probe
cpu_rdata  out  DATA_W  data to CPU (= ram_rdata always)
ram_wrEn  out  1  RAM write enable
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, 1-cycle synchronous latency
busy  out  1  state is LOAD or RUN
halted  out  1  state is HALT
timeout  out  1  sticky: last run ended by MAX_CYCLES
load_err  out  1  sticky: load overflowed address space
cycle_count  out  32  RUN cycles of last/current run, saturating
final_pc  out  ADDR_W  cpu_pc captured on HALT entry

Behaviour:
- Reset (async, any time, including mid-load/mid-run): state=IDLE; load_addr=LOAD_BASE; stable_cnt=0; cycle_count=0; final_pc=0; timeout=0; load_err=0; rd_valid=0; pc_prev=0.
- Combinational outputs under reset: ram_wrEn=0, ram_addr=0, ram_wdata=0, ld_ready=0, cpu_rst=1, busy=0, halted=0.
- States: IDLE=0, LOAD=1, RUN=2, HALT=3.
- cpu_rst = (state != RUN), decoded from the state register.
- ld_ready = (state == LOAD). busy and halted are decoded from state.
- ram_* default: wrEn=0, addr=0, wdata=0.
- IDLE/HALT transitions:
  - load_start -> LOAD; load_addr=LOAD_BASE; load_err cleared.
  - else run_start -> RUN; cycle_count=0, stable_cnt=0, timeout=0, pc_prev=cpu_pc.
  - load_start wins if both pulses arrive together.
- LOAD:
  - On ld_valid&ld_ready, same cycle: ram_wrEn=1, ram_addr=load_addr, ram_wdata=ld_data. Then load_addr++.
  - Accepted ld_last -> IDLE.
  - Word accepted at load_addr = 2^ADDR_W-1 without ld_last: word is written, load_err=1, -> IDLE (no wrap).
  - run_start and rd_req are ignored.
- RUN:
  - ram_wrEn/addr/wdata = cpu_wrEn/cpu_addr/cpu_wdata, combinational pass-through.
  - cycle_count++ each cycle, saturating at 2^32-1.
  - Halt detection: if cpu_pc==pc_prev, stable_cnt++; else stable_cnt=0. pc_prev<=cpu_pc.
  - When stable_cnt reaches HALT_WINDOW-1 with PC still equal: -> HALT, final_pc=cpu_pc.
  - Priority, highest first: abort -> HALT; then cycle_count==MAX_CYCLES-1 -> HALT with timeout=1; then PC halt.
  - load_start/run_start in RUN are ignored.
- HALT: the CPU is held in reset. State persists until load_start or run_start.
- Host read, accepted in IDLE or HALT only:
  - Cycle T with rd_req: ram_addr=rd_addr, ram_wrEn=0.
  - Cycle T+1: rd_valid=1, rd_data=ram_rdata.
  - Back-to-back requests give one result per cycle.
  - rd_req in LOAD/RUN: no RAM access, rd_valid=0 next cycle.
  - A state change between T and T+1 does not cancel the pending rd_valid.
  - rd_data=0 whenever rd_valid=0.

Test Plan:
- Load 4 words 0xC005,0x2006,0xE007,0xA008 with ld_last on word 4, ld_valid gaps inserted -> RAM[0..3] match exactly, load_addr stops at 4, state IDLE, load_err=0.
- Load then run a program ending in a BZ-to-self at PC=3 -> CPU executes, halted=1, final_pc=3, timeout=0; HALT entered exactly HALT_WINDOW cycles after PC first settles at 3.
- Program with an infinite ADD loop, MAX_CYCLES=50 -> HALT after exactly 50 RUN cycles, cycle_count=50, timeout=1.
- After halt, rd_req for addresses 7 then 8 on consecutive cycles -> rd_valid high on the two following cycles with stored values; rd_req during RUN -> rd_valid stays 0.
- Load starting at 2^ADDR_W-2 (LOAD_BASE override) with 3 words and no ld_last -> 2 words written, load_err=1, IDLE.
- Assert rst mid-RUN and mid-LOAD -> ram_wrEn=0 and cpu_rst=1 immediately, all registers at reset values; a simultaneous load_start+run_start from IDLE -> LOAD.
